// File: rtl/md_ctrl.sv
// md_ctrl: multiply/divide sequencer that owns HI/LO, models fixed mult/div latency and requests D-stage stalls.
// Optional `MD_FLUSH_EN adds an md_flush input that aborts an in-flight op and suppresses same-edge starts.
module md_ctrl #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        md_start,
  input  logic [2:0]  md_op,
  input  logic [31:0] md_a,
  input  logic [31:0] md_b,
`ifdef MD_FLUSH_EN
  input  logic        md_flush,
`endif
  input  logic        id_is_md,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        md_stall
);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  localparam logic [3:0] MULT_LAST = 4'(MULT_CYCLES - 1);
  localparam logic [3:0] DIV_LAST  = 4'(DIV_CYCLES - 1);

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  state_t      state, state_n;
  logic [3:0]  cnt, cnt_n;
  logic [31:0] hi_n, lo_n;
  logic [31:0] pend_hi, pend_hi_n;
  logic [31:0] pend_lo, pend_lo_n;
  logic        pend_ok, pend_ok_n;
  logic        flush;

`ifdef MD_FLUSH_EN
  assign flush = md_flush;
`else
  assign flush = 1'b0;
`endif

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic [31:0] div_b;
  logic [31:0] quot_s, rem_s;
  logic [31:0] quot_u, rem_u;
  logic        long_op;

  assign prod_s = $signed({{32{md_a[31]}}, md_a}) * $signed({{32{md_b[31]}}, md_b});
  assign prod_u = {32'd0, md_a} * {32'd0, md_b};

  // A zero divisor is swapped for 1 so the dividers never produce X; that result is never committed.
  assign div_b  = (md_b == 32'd0) ? 32'd1 : md_b;
  assign quot_s = $signed(md_a) / $signed(div_b);
  assign rem_s  = $signed(md_a) % $signed(div_b);
  assign quot_u = md_a / div_b;
  assign rem_u  = md_a % div_b;

  assign long_op = (md_op == OP_MULT) || (md_op == OP_MULTU) ||
                   (md_op == OP_DIV)  || (md_op == OP_DIVU);

  assign busy     = (state == BUSY);
  assign md_stall = id_is_md && (busy || (md_start && long_op));

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    hi_n      = hi;
    lo_n      = lo;
    pend_hi_n = pend_hi;
    pend_lo_n = pend_lo;
    pend_ok_n = pend_ok;
    case (state)
      IDLE: begin
        if (md_start && !flush) begin
          case (md_op)
            OP_MULT: begin
              {pend_hi_n, pend_lo_n} = prod_s;
              pend_ok_n = 1'b1;
              cnt_n     = MULT_LAST;
              state_n   = BUSY;
            end
            OP_MULTU: begin
              {pend_hi_n, pend_lo_n} = prod_u;
              pend_ok_n = 1'b1;
              cnt_n     = MULT_LAST;
              state_n   = BUSY;
            end
            OP_DIV: begin
              pend_hi_n = rem_s;
              pend_lo_n = quot_s;
              pend_ok_n = (md_b != 32'd0);
              cnt_n     = DIV_LAST;
              state_n   = BUSY;
            end
            OP_DIVU: begin
              pend_hi_n = rem_u;
              pend_lo_n = quot_u;
              pend_ok_n = (md_b != 32'd0);
              cnt_n     = DIV_LAST;
              state_n   = BUSY;
            end
            OP_MTHI: hi_n = md_a;
            OP_MTLO: lo_n = md_a;
            default: ;
          endcase
        end
      end
      BUSY: begin
        // Flush takes priority over the final-count commit.
        if (flush) begin
          state_n   = IDLE;
          cnt_n     = 4'd0;
          pend_ok_n = 1'b0;
        end else if (cnt != 4'd0) begin
          cnt_n = cnt - 4'd1;
        end else begin
          if (pend_ok) begin
            hi_n = pend_hi;
            lo_n = pend_lo;
          end
          pend_ok_n = 1'b0;
          state_n   = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      hi      <= 32'd0;
      lo      <= 32'd0;
      pend_hi <= 32'd0;
      pend_lo <= 32'd0;
      pend_ok <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      hi      <= hi_n;
      lo      <= lo_n;
      pend_hi <= pend_hi_n;
      pend_lo <= pend_lo_n;
      pend_ok <= pend_ok_n;
    end
  end

endmodule
